// File: rtl/stream_demux1x16_if.sv
// Handshake bundle for the 1-to-16 stream distributor: one input stream in,
// sixteen independent valid/ready lanes out.
interface stream_demux1x16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic [3:0]          in_sel;
    logic                in_bcast;
    logic                in_ready;
    logic [16*WIDTH-1:0] out_data;
    logic [15:0]         out_valid;
    logic [15:0]         out_ready;
    logic                busy;

    modport master (
        output in_data,
        output in_valid,
        output in_sel,
        output in_bcast,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sel,
        input  in_bcast,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/stream_demux1x16.sv
// 1-to-16 stream distributor: steers each accepted word to one lane (or all
// lanes on broadcast); every lane owns a one-entry holding register.
module stream_demux1x16 #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    stream_demux1x16_if.slave bus
);
    localparam int LANES = 16;

    logic [LANES-1:0]            lane_free_s;
    logic [LANES-1:0]            load_s;
    logic                        ready_s;
    logic                        accept_s;
    logic [LANES-1:0]            valid_r;
    logic [LANES-1:0][WIDTH-1:0] data_r;

    // A lane can take a word if empty or draining on this same edge
    always_comb begin
        lane_free_s = ~valid_r | bus.out_ready;
        if (rst) begin
            ready_s = 1'b0;
        end else if (bus.in_bcast) begin
            ready_s = &lane_free_s;
        end else begin
            ready_s = lane_free_s[bus.in_sel];
        end
    end

    // Decode accepted transfer into per-lane load strobes; broadcast is all-or-nothing
    always_comb begin
        accept_s = bus.in_valid & ready_s;
        load_s   = '0;
        if (accept_s) begin
            if (bus.in_bcast) begin
                load_s = '1;
            end else begin
                load_s[bus.in_sel] = 1'b1;
            end
        end else begin
            load_s = '0;
        end
    end

    // Per-lane holding registers; a load wins over a drain on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (load_s[i]) begin
                    data_r[i]  <= bus.in_data;
                    valid_r[i] <= 1'b1;
                end else if (valid_r[i] && bus.out_ready[i]) begin
                    valid_r[i] <= 1'b0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.busy      = |valid_r;
endmodule

// File: doc/stream_demux1x16.md
Name: stream_demux1x16

Overview:
- 1-to-16 stream distributor with valid/ready handshake. It is the write-side counterpart of the 16:1 operand select mux.
- Steers one input word to one of 16 output lanes, or to all 16 in broadcast mode.
- Each lane has a one-entry registered holding buffer, so a stalled consumer never blocks the other lanes.
- Sits between a PE result port and the interconnect fan-out toward neighbouring PEs and memory ports.

Parameters:
- WIDTH, 16, data width of the input word and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input word
- in_valid  input  1  input word present
- in_sel  input  4  destination lane index 0..15; sampled with in_valid
- in_bcast  input  1  when 1, deliver to all 16 lanes; in_sel ignored
- in_ready  output  1  input transfer accepted this cycle when in_valid & in_ready
- out_data  output  16*WIDTH  lane i data at bits [i*WIDTH +: WIDTH]
- out_valid  output  16  per-lane valid
- out_ready  input  16  per-lane consumer ready
- busy  output  1  OR of out_valid

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid <= 0 and all out_data lanes <= 0.
  - in_ready is forced to 0 combinationally while rst=1.
  - A reset mid-transfer discards all held words; no partial delivery.
- Lane free condition: lane_free[i] = ~out_valid[i] | out_ready[i]. Combinational, so it passes out_ready through to in_ready in the same cycle.
- in_ready when rst=0:
  - in_bcast=0: in_ready = lane_free[in_sel].
  - in_bcast=1: in_ready = AND of all lane_free.
  - in_ready does not depend on in_valid.
- Accept = in_valid & in_ready.
  - Unicast: lane in_sel loads in_data, and out_valid[in_sel] <= 1.
  - Broadcast: all 16 lanes load in_data, and all out_valid <= 1.
  - Broadcast is all-or-nothing; it never partially delivers.
- Latency: an accepted word appears on out_data/out_valid on the cycle after acceptance (1 cycle).
- Per-lane update, in priority order:
  1. Load this cycle -> data <= in_data, valid <= 1. This holds even if the old word drains on the same edge: back-to-back throughput of 1 word/cycle per lane.
  2. Else, out_valid[i] & out_ready[i] -> valid <= 0; data keeps its last value.
  3. Else hold.
- While out_valid[i]=1 and out_ready[i]=0, out_data lane i stays stable and is never overwritten.
- out_ready on a lane with out_valid=0 has no effect.
- Lanes are independent: a stalled lane only blocks inputs targeting that lane, and broadcasts.
- busy = |out_valid (combinational from registers).
- No internal FSM beyond the per-lane full/empty bit. No ordering guarantee across lanes; within a lane, words leave in acceptance order.

Test Plan:
- Reset, then single unicast: in_data=0x1234, in_sel=5, in_valid=1, all out_ready=0.
  - in_ready=1.
  - Next cycle: out_valid=0x0020, lane 5 data=0x1234, busy=1.
  - Other lanes stay 0.
- Stall and overwrite protection: with lane 5 full and out_ready[5]=0, present 0xBEEF to in_sel=5.
  - in_ready=0 and lane 5 holds 0x1234.
  - Present 0xBEEF to in_sel=6 instead: accepted, out_valid=0x0060.
- Streaming: out_ready[3]=1 constantly; present words 1,2,3,4 to lane 3 on consecutive cycles.
  - in_ready=1 every cycle.
  - Lane 3 shows 1,2,3,4 on the following four cycles.
  - out_valid[3] stays 1 throughout, then drops 1 cycle after the last word is consumed.
- Broadcast: in_bcast=1, in_data=0x00FF, all lanes empty.
  - out_valid=0xFFFF next cycle, all lanes 0x00FF.
  - Repeat with lane 9 full and out_ready[9]=0: in_ready=0, and no lane changes.
  - Assert out_ready[9]=1: accepted that cycle, all lanes 0x00FF.
- Reset mid-operation: lanes 0, 7, 15 full; assert rst for one cycle with in_valid=1.
  - in_ready=0 during reset.
  - After the edge: out_valid=0, all out_data=0, busy=0.
  - The first post-reset accept behaves as in the first test.
- Sweep: for s=0..15, send data=s*0x1111 with out_ready all 1.
  - Each lane s receives exactly its word one cycle later.
  - No other lane's out_valid toggles.
